conv_mac_pipe: RTL and testbench
================================

CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: unsigned pixel width.
REQ-002 SHALL have parameter KERNEL_ROW_SIZE, default 3: kernel rows.
REQ-003 SHALL have parameter KERNEL_COLUMN_SIZE, default 3: kernel columns; N = KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE.
REQ-004 SHALL have parameter WEIGHT_WIDTH, default 8: signed two's-complement weight width.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_matrix  input  N*DATA_WIDTH  window from line-buffer stage; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 valid_in  input  1  in_matrix valid this cycle; no backpressure.
REQ-009 load_start  input  1  pulse: begin serial weight load.
REQ-010 weight_in  input  WEIGHT_WIDTH  serial weight, element 0 first.
REQ-011 weight_valid  input  1  weight_in valid this cycle.
REQ-012 bias_in  input  ACC_WIDTH  signed bias, sampled on load_start.
REQ-013 shift  input  5  right-shift applied before quantization, sampled on load_start.
REQ-014 out_point  output  DATA_WIDTH  quantized result.
REQ-015 valid_out  output  1  out_point valid; single-cycle per result.
REQ-016 sat_flag  output  1  qualified by valid_out; result clamped high.
REQ-017 load_busy  output  1  high while in LOAD.
REQ-018 drop_pulse  output  1  one-cycle pulse when valid_in arrives with no committed weights.

Function
REQ-019 ACC_WIDTH SHALL be DATA_WIDTH+WEIGHT_WIDTH+1+clog2(N); all accumulation signed at ACC_WIDTH, no internal overflow possible.
REQ-020 Result SHALL be bias + sum over k of zero-extended pixel[k] * signed weight[k].
REQ-021 Pipeline: S1 register N products; S2 register per-row sums; S3 register total + bias; S4 register quantized output; latency exactly 4 cycles valid_in -> valid_out, throughput 1/cycle.
REQ-022 Quantization: arithmetic right shift by shift; negative -> 0 (ReLU); > 2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1 with sat_flag=1; otherwise low DATA_WIDTH bits, sat_flag=0.
REQ-023 FSM states IDLE (no committed bank), LOAD, RUN.
REQ-024 IDLE -> LOAD and RUN -> LOAD on load_start; LOAD on load_start restarts count at 0 and resamples bias/shift.
REQ-025 In LOAD each weight_valid writes weight_in to shadow[count], count++; on the N-th write shadow, bias, shift commit atomically to active bank next edge, FSM -> RUN.
REQ-026 Windows SHALL be accepted whenever a committed bank exists (RUN, or LOAD entered from RUN) using the active bank; shadow never affects in-flight data.
REQ-027 valid_in on the commit edge SHALL use the old bank; the following cycle uses the new bank.
REQ-028 valid_in with no committed bank SHALL be dropped (no valid_out) and drop_pulse raised for that cycle.
REQ-029 weight_valid outside LOAD SHALL be ignored; load_start and weight_valid same cycle: restart, then that weight written as element 0.
REQ-030 out_point and sat_flag SHALL hold last value when valid_out=0.

Reset
REQ-031 On rst: FSM IDLE, count 0, all pipeline valids 0, active/shadow weights, bias, shift 0, out_point 0, valid_out 0, sat_flag 0, load_busy 0, drop_pulse 0.
REQ-032 rst mid-pipeline SHALL discard all in-flight windows; no valid_out in cycle after rst deasserts.
REQ-033 rst mid-load SHALL discard partial weights; block returns to IDLE.

Structure
REQ-034 Package conv_pkg SHALL hold ACC_WIDTH function, FSM state enum, and shift width constant; shared with conv_buffer consumers.
REQ-035 Quantizer (shift, ReLU, saturate) SHALL be sub-module conv_quant, combinational, registered by parent S4.

Verification
REQ-036 Load w4=1 others 0, bias 0, shift 0; window element k = k+1 -> out_point 5, valid_out exactly 4 cycles after valid_in.
REQ-037 All weights 1, bias 0; window all 255: shift 0 -> 255 sat_flag 1; shift 4 -> 143 sat_flag 0.
REQ-038 All weights -1, window all 10 -> out_point 0, sat_flag 0; bias 100 same window -> 10.
REQ-039 valid_in before any load -> drop_pulse each cycle, no valid_out.
REQ-040 Continuous windows (all 2) with weights all 1 (result 18); reload weights all 2 mid-stream -> results 18 through commit-edge window, 36 thereafter, no gaps.
REQ-041 rst asserted 2 cycles after valid_in burst -> no valid_out; drop_pulse on next valid_in until reload.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC pipeline and its line-buffer neighbours:
// accumulator sizing, weight-load FSM states and the quantizer shift width.
package conv_pkg;

    localparam int SHIFT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } conv_state_t;

    // Wide enough for N products of unsigned pixel x signed weight plus bias.
    function automatic int acc_width(input int data_w, input int weight_w, input int n);
        return data_w + weight_w + 1 + $clog2(n);
    endfunction

endpackage

// File: rtl/conv_quant.sv
// Combinational quantizer: arithmetic right shift, ReLU at zero, clamp to the
// unsigned pixel range with a saturation flag.
module conv_quant
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic [SHIFT_W-1:0]          shift_i,
    output logic [DATA_WIDTH-1:0]       q_o,
    output logic                        sat_o
);

    // Returns {sat, value}.
    function automatic logic [DATA_WIDTH:0] relu_sat(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] max_v;
        max_v = $signed({{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});
        if (v[ACC_WIDTH-1]) begin
            return '0;
        end
        if (v > max_v) begin
            return {1'b1, {DATA_WIDTH{1'b1}}};
        end
        return {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    logic signed [ACC_WIDTH-1:0] shifted;
    logic [DATA_WIDTH:0]         res;

    assign shifted = acc_i >>> shift_i;
    assign res     = relu_sat(shifted);
    assign sat_o   = res[DATA_WIDTH];
    assign q_o     = res[DATA_WIDTH-1:0];

endmodule

// File: rtl/conv_mac_pipe.sv
// Four-stage convolution MAC: products, row sums, total+bias, quantized output.
// Weights are loaded serially into a shadow bank and committed atomically.
module conv_mac_pipe
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int KERNEL_ROW_SIZE    = 3,
    parameter int KERNEL_COLUMN_SIZE = 3,
    parameter int WEIGHT_WIDTH       = 8,
    localparam int N         = KERNEL_ROW_SIZE * KERNEL_COLUMN_SIZE,
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, WEIGHT_WIDTH, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*DATA_WIDTH-1:0] in_matrix,
    input  logic                    valid_in,
    input  logic                    load_start,
    input  logic [WEIGHT_WIDTH-1:0] weight_in,
    input  logic                    weight_valid,
    input  logic [ACC_WIDTH-1:0]    bias_in,
    input  logic [SHIFT_W-1:0]      shift,
    output logic [DATA_WIDTH-1:0]   out_point,
    output logic                    valid_out,
    output logic                    sat_flag,
    output logic                    load_busy,
    output logic                    drop_pulse
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    conv_state_t                    state_q;
    logic [CNT_W-1:0]               count_q;
    logic                           bank_q;
    logic signed [WEIGHT_WIDTH-1:0] shadow_q [N];
    logic signed [WEIGHT_WIDTH-1:0] shadow_d [N];
    logic signed [WEIGHT_WIDTH-1:0] active_q [N];
    logic signed [ACC_WIDTH-1:0]    sbias_q, sbias_d, abias_q;
    logic [SHIFT_W-1:0]             sshift_q, sshift_d, ashift_q;

    logic [CNT_W-1:0] wr_idx;
    logic             wr_en;
    logic             commit;
    logic             accept;

    // A write on the last index folds into the committed bank on the same edge.
    always_comb begin
        wr_idx   = load_start ? '0 : count_q;
        wr_en    = weight_valid && (load_start || (state_q == ST_LOAD));
        commit   = wr_en && (wr_idx == CNT_W'(N-1));
        sbias_d  = load_start ? $signed(bias_in) : sbias_q;
        sshift_d = load_start ? shift : sshift_q;
        for (int k = 0; k < N; k++) begin
            shadow_d[k] = shadow_q[k];
        end
        if (wr_en) begin
            shadow_d[wr_idx] = weight_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            bank_q   <= 1'b0;
            sbias_q  <= '0;
            sshift_q <= '0;
            abias_q  <= '0;
            ashift_q <= '0;
            for (int k = 0; k < N; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            sbias_q  <= sbias_d;
            sshift_q <= sshift_d;
            for (int k = 0; k < N; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            if (commit) begin
                for (int k = 0; k < N; k++) begin
                    active_q[k] <= shadow_d[k];
                end
                abias_q  <= sbias_d;
                ashift_q <= sshift_d;
                bank_q   <= 1'b1;
                state_q  <= ST_RUN;
                count_q  <= '0;
            end else if (load_start) begin
                state_q <= ST_LOAD;
                count_q <= wr_en ? CNT_W'(1) : '0;
            end else if (wr_en) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign accept     = valid_in && bank_q;
    assign drop_pulse = valid_in && !bank_q && !rst;
    assign load_busy  = (state_q == ST_LOAD);

    function automatic logic signed [ACC_WIDTH-1:0] mac_prod(
        input logic [DATA_WIDTH-1:0]          pix,
        input logic signed [WEIGHT_WIDTH-1:0] w
    );
        logic signed [ACC_WIDTH-1:0] p_ext;
        logic signed [ACC_WIDTH-1:0] w_ext;
        p_ext = $signed({{(ACC_WIDTH-DATA_WIDTH){1'b0}}, pix});
        w_ext = ACC_WIDTH'(w);
        return p_ext * w_ext;
    endfunction

    logic                        vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    logic signed [ACC_WIDTH-1:0] prod_p1_q [N];
    logic signed [ACC_WIDTH-1:0] rsum_d    [KERNEL_ROW_SIZE];
    logic signed [ACC_WIDTH-1:0] rsum_p2_q [KERNEL_ROW_SIZE];
    logic signed [ACC_WIDTH-1:0] total_d, total_p3_q;
    logic signed [ACC_WIDTH-1:0] bias_p1_q, bias_p2_q;
    logic [SHIFT_W-1:0]          shift_p1_q, shift_p2_q, shift_p3_q;
    logic [DATA_WIDTH-1:0]       q_d, out_p4_q;
    logic                        sat_d, sat_p4_q;

    always_comb begin
        for (int r = 0; r < KERNEL_ROW_SIZE; r++) begin
            rsum_d[r] = '0;
            for (int c = 0; c < KERNEL_COLUMN_SIZE; c++) begin
                rsum_d[r] = rsum_d[r] + prod_p1_q[r*KERNEL_COLUMN_SIZE + c];
            end
        end
        total_d = bias_p2_q;
        for (int r = 0; r < KERNEL_ROW_SIZE; r++) begin
            total_d = total_d + rsum_p2_q[r];
        end
    end

    conv_quant #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_quant (
        .acc_i   (total_p3_q),
        .shift_i (shift_p3_q),
        .q_o     (q_d),
        .sat_o   (sat_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            vld_p4_q <= 1'b0;
            out_p4_q <= '0;
            sat_p4_q <= 1'b0;
        end else begin
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            vld_p4_q <= vld_p3_q;
            // S4: quantized result, held between valid cycles
            if (vld_p3_q) begin
                out_p4_q <= q_d;
                sat_p4_q <= sat_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        // S1: products against the active bank; bias/shift travel with the window
        for (int k = 0; k < N; k++) begin
            prod_p1_q[k] <= mac_prod(in_matrix[k*DATA_WIDTH +: DATA_WIDTH], active_q[k]);
        end
        bias_p1_q  <= abias_q;
        shift_p1_q <= ashift_q;
        // S2: per-row sums
        for (int r = 0; r < KERNEL_ROW_SIZE; r++) begin
            rsum_p2_q[r] <= rsum_d[r];
        end
        bias_p2_q  <= bias_p1_q;
        shift_p2_q <= shift_p1_q;
        // S3: total plus bias
        total_p3_q <= total_d;
        shift_p3_q <= shift_p2_q;
    end

    assign valid_out = vld_p4_q;
    assign out_point = out_p4_q;
    assign sat_flag  = sat_p4_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe with a queue-based reference model and
// hand-computed expectations for the key scenarios.
module tb_conv_mac_pipe;

    localparam int DW = 8;
    localparam int KR = 3;
    localparam int KC = 3;
    localparam int WW = 8;
    localparam int N  = KR * KC;
    localparam int AW = DW + WW + 1 + $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] in_matrix = '0;
    logic            valid_in = 1'b0;
    logic            load_start = 1'b0;
    logic [WW-1:0]   weight_in = '0;
    logic            weight_valid = 1'b0;
    logic [AW-1:0]   bias_in = '0;
    logic [4:0]      shift = '0;
    logic [DW-1:0]   out_point;
    logic            valid_out;
    logic            sat_flag;
    logic            load_busy;
    logic            drop_pulse;

    always #5 clk = ~clk;

    conv_mac_pipe #(
        .DATA_WIDTH         (DW),
        .KERNEL_ROW_SIZE    (KR),
        .KERNEL_COLUMN_SIZE (KC),
        .WEIGHT_WIDTH       (WW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_matrix    (in_matrix),
        .valid_in     (valid_in),
        .load_start   (load_start),
        .weight_in    (weight_in),
        .weight_valid (weight_valid),
        .bias_in      (bias_in),
        .shift        (shift),
        .out_point    (out_point),
        .valid_out    (valid_out),
        .sat_flag     (sat_flag),
        .load_busy    (load_busy),
        .drop_pulse   (drop_pulse)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a window computes bias + sum(pixel*weight) with the bank
    // committed before its sampling edge; the result is due 3 edges later.
    typedef struct {
        int due;
        int val;
        bit sat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    bit   m_have = 0;
    bit   m_loading = 0;
    int   m_cnt = 0;
    int   m_sw[N];
    int   m_aw[N];
    int   m_sb = 0, m_ab = 0, m_ss = 0, m_as = 0;
    int   acc, t;
    bit   exp_vo = 0;
    int   exp_val = 0;
    bit   exp_sat = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            m_have    = 0;
            m_loading = 0;
            m_cnt     = 0;
            exp_vo    = 0;
            exp_val   = 0;
            exp_sat   = 0;
        end else begin
            if (valid_in && m_have) begin
                acc = m_ab;
                for (int k = 0; k < N; k++) begin
                    acc += int'(in_matrix[k*DW +: DW]) * m_aw[k];
                end
                t = acc >>> m_as;
                e.due = cyc + 3;
                if (t < 0) begin
                    e.val = 0;
                    e.sat = 0;
                end else if (t > (1 << DW) - 1) begin
                    e.val = (1 << DW) - 1;
                    e.sat = 1;
                end else begin
                    e.val = t;
                    e.sat = 0;
                end
                q.push_back(e);
            end
            if (load_start) begin
                m_loading = 1;
                m_cnt     = 0;
                m_sb      = int'($signed(bias_in));
                m_ss      = int'(shift);
            end
            if (weight_valid && m_loading) begin
                m_sw[m_cnt] = int'($signed(weight_in));
                m_cnt++;
                if (m_cnt == N) begin
                    m_aw      = m_sw;
                    m_ab      = m_sb;
                    m_as      = m_ss;
                    m_have    = 1;
                    m_loading = 0;
                    m_cnt     = 0;
                end
            end
            exp_vo = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e       = q.pop_front();
                exp_vo  = 1;
                exp_val = e.val;
                exp_sat = e.sat;
            end
        end
    end

    int n_vo = 0;
    int vo_vals[$];

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cmp_valid_out", valid_out, exp_vo);
            chk("cmp_out_point", out_point, exp_val);
            chk("cmp_sat_flag", sat_flag, exp_sat);
            chk("cmp_load_busy", load_busy, m_loading);
            chk("cmp_drop_pulse", drop_pulse, valid_in && !m_have && !rst);
            if (valid_out) begin
                n_vo++;
                vo_vals.push_back(int'(out_point));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_win(input int base, input int inc);
        for (int k = 0; k < N; k++) begin
            in_matrix[k*DW +: DW] = DW'(base + inc * k);
        end
        valid_in = 1'b1;
    endtask

    // First weight shares the load_start cycle.
    task automatic load_bank(input int w[N], input int b, input int sh);
        load_start = 1'b1;
        bias_in    = AW'(b);
        shift      = 5'(sh);
        for (int k = 0; k < N; k++) begin
            weight_in    = WW'(w[k]);
            weight_valid = 1'b1;
            step();
            load_start = 1'b0;
        end
        weight_valid = 1'b0;
    endtask

    task automatic run_window(input int base, input int inc,
                              output logic vo, output logic [DW-1:0] v, output logic s);
        drive_win(base, inc);
        step();
        valid_in = 1'b0;
        repeat (3) step();
        vo = valid_out;
        v  = out_point;
        s  = sat_flag;
    endtask

    int            wv[N];
    int            w1[N];
    int            w2[N];
    logic          r_vo;
    logic [DW-1:0] r_v;
    logic          r_s;
    int            n0, s0, n18, n36;

    initial begin
        for (int k = 0; k < N; k++) begin
            w1[k] = 1;
            w2[k] = 2;
        end

        repeat (3) step();
        chk("rst_out_point", out_point, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_load_busy", load_busy, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        rst = 1'b0;
        step();

        // windows before any bank is committed are dropped
        drive_win(3, 0);
        step();
        chk("drop_no_bank", drop_pulse, 1);
        repeat (3) step();
        valid_in = 1'b0;
        repeat (6) step();
        chk("no_vo_before_load", n_vo, 0);

        // partial load, then a restart that must overwrite from element 0
        load_start   = 1'b1;
        weight_in    = WW'(7);
        weight_valid = 1'b1;
        step();
        load_start = 1'b0;
        repeat (3) step();
        weight_valid = 1'b0;
        chk("busy_in_load", load_busy, 1);
        for (int k = 0; k < N; k++) wv[k] = (k == 4) ? 1 : 0;
        load_bank(wv, 0, 0);
        chk("busy_after_commit", load_busy, 0);

        // centre tap: window k+1 selects element 4 -> 5, 4-cycle latency
        drive_win(1, 1);
        step();
        valid_in = 1'b0;
        step();
        step();
        chk("lat_not_early", valid_out, 0);
        step();
        chk("lat_vo", valid_out, 1);
        chk("w4_out", out_point, 5);
        step();
        chk("vo_single_cycle", valid_out, 0);
        chk("hold_out", out_point, 5);

        // all-ones kernel on 255: saturate, then shift 4 -> 2295>>4 = 143
        load_bank(w1, 0, 0);
        run_window(255, 0, r_vo, r_v, r_s);
        chk("sat_vo", r_vo, 1);
        chk("sat_out", r_v, 255);
        chk("sat_flag_hi", r_s, 1);
        weight_in    = WW'(5);
        weight_valid = 1'b1;
        repeat (3) step();
        weight_valid = 1'b0;
        load_bank(w1, 0, 4);
        run_window(255, 0, r_vo, r_v, r_s);
        chk("shift4_out", r_v, 143);
        chk("shift4_sat", r_s, 0);

        // negative kernel: -90 -> ReLU 0; with bias 100 -> 10
        for (int k = 0; k < N; k++) wv[k] = -1;
        load_bank(wv, 0, 0);
        run_window(10, 0, r_vo, r_v, r_s);
        chk("relu_out", r_v, 0);
        chk("relu_sat", r_s, 0);
        load_bank(wv, 100, 0);
        run_window(10, 0, r_vo, r_v, r_s);
        chk("bias_out", r_v, 10);
        chk("bias_sat", r_s, 0);

        // reload mid-stream: 14 windows on the old bank (through commit edge), then 11 new
        load_bank(w1, 0, 0);
        step();
        s0 = vo_vals.size();
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    drive_win(2, 0);
                    step();
                end
                valid_in = 1'b0;
            end
            begin
                repeat (5) step();
                load_bank(w2, 0, 0);
            end
        join
        repeat (6) step();
        n18 = 0;
        n36 = 0;
        for (int i = s0; i < vo_vals.size(); i++) begin
            if (vo_vals[i] == 18 && n36 == 0) n18++;
            if (vo_vals[i] == 36) n36++;
        end
        chk("stream_count", vo_vals.size() - s0, 25);
        chk("stream_old_bank", n18, 14);
        chk("stream_new_bank", n36, 11);

        // reset two cycles into a burst flushes it and forgets the bank
        n0 = n_vo;
        drive_win(2, 0);
        step();
        step();
        valid_in = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("rst_flush_no_vo", n_vo, n0);
        drive_win(2, 0);
        step();
        chk("drop_after_rst", drop_pulse, 1);
        valid_in = 1'b0;
        step();

        // reset during a load returns to IDLE with nothing committed
        load_bank(w1, 0, 0);
        load_start   = 1'b1;
        weight_in    = WW'(3);
        weight_valid = 1'b1;
        step();
        load_start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        weight_valid = 1'b0;
        chk("rst_midload_busy", load_busy, 0);
        drive_win(4, 0);
        step();
        chk("drop_after_midload_rst", drop_pulse, 1);
        valid_in = 1'b0;
        step();
        load_bank(w1, 0, 0);
        run_window(4, 0, r_vo, r_v, r_s);
        chk("recover_vo", r_vo, 1);
        chk("recover_out", r_v, 36);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
